radix4_operand_loader: RTL and testbench
========================================

Name: radix4_operand_loader

Overview:
- Front-end stage that drives the Radix-4 multiplier on the FPGA board.
- Synchronises and debounces the active-low load/go push-buttons and captures the 8-bit switch value into operand registers A and B.
- Issues a single-cycle start pulse to the multiplier, then tracks its done pulse so the user cannot reload operands mid-multiply.

Parameters:
- WIDTH, 8, operand width (switch bus, op_a, op_b).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a key level change (bench uses 4).
- TIMEOUT_CYCLES, 64, RUN watchdog limit; used only when OPLOAD_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- sw  input  WIDTH  raw switch value.
- key_a_n  input  1  raw active-low "load A" button.
- key_b_n  input  1  raw active-low "load B" button.
- key_go_n  input  1  raw active-low "start" button.
- mult_done  input  1  done pulse from the multiplier.
- op_a  output  WIDTH  registered operand A.
- op_b  output  WIDTH  registered operand B.
- mult_start  output  1  one-cycle start pulse to the multiplier.
- a_valid  output  1  A loaded since last clear.
- b_valid  output  1  B loaded since last clear.
- busy  output  1  high in START and RUN.
- err  output  1  watchdog error flag (see Optional Feature).

Behaviour:
- Reset (rst high at a clock edge):
  - op_a, op_b = 0; a_valid, b_valid, mult_start, busy, err = 0.
  - State = LOAD; debounced key levels = 1 (released); debounce counters = 0.
  - Reset mid-RUN abandons the multiply; any later mult_done is ignored because the state is LOAD.
- Input path:
  - Each key and the sw bus pass through a 2-FF synchroniser.
  - Per key, a counter increments while the synced level differs from the debounced level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A 1→0 transition of the debounced level produces a one-cycle press pulse in the following cycle. Release generates nothing.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- FSM states: LOAD, START, RUN, DONE.
  - LOAD, press_a: op_a ← synced sw; a_valid ← 1.
  - LOAD, press_b: op_b ← synced sw; b_valid ← 1.
  - LOAD, press_a and press_b in the same cycle: both registers get the same sw value.
  - LOAD, press_go with a_valid and b_valid both 1 → START. press_go with either valid low is ignored (stay in LOAD).
  - LOAD, press_go in the same cycle as a load press: the load happens; go is evaluated against the pre-edge valid flags.
  - START: mult_start = 1 for exactly one cycle; busy = 1; next state RUN.
  - RUN: busy = 1; all presses ignored; mult_done → DONE. A mult_done coinciding with START is ignored.
  - DONE: busy = 0; operands are held.
    - press_a or press_b: load that register, clear the other valid flag, go to LOAD.
    - press_go: re-run the same operands → START.
- mult_start is asserted only in START. op_a and op_b never change while busy = 1.

Optional Feature:
- Macro: OPLOAD_TIMEOUT_EN.
- Defined:
  - A counter runs in RUN; if TIMEOUT_CYCLES cycles elapse without mult_done, the FSM goes to DONE with err = 1.
  - err clears on the next START or on reset.
- Not defined: no counter is built; err is tied to 0; RUN waits indefinitely.

Test Plan (WIDTH=8, DEBOUNCE_CYCLES=4):
1. Reset, then hold key_a_n low 10 cycles with sw=0xFF → op_a=0xFF and a_valid=1 exactly 2+4+1 cycles after the first low sample; one load only.
2. key_b_n low-pulse of 3 cycles with sw=0x04 → no load, b_valid stays 0. Then a 10-cycle press → op_b=0x04, b_valid=1.
3. With A=0xFF and B=0x04 loaded, press go → a single mult_start pulse, busy=1. Keys A/B pressed during RUN leave op_a/op_b unchanged. mult_done pulse → busy=0 in the next cycle.
4. Press go with only a_valid=1 → no mult_start, state remains LOAD.
5. Assert rst in RUN → all outputs 0 next cycle. A later mult_done pulse causes no state change.
6. With OPLOAD_TIMEOUT_EN and TIMEOUT_CYCLES=64: start, withhold mult_done → err=1 and busy=0 after 64 RUN cycles. The next go clears err.

Source files
------------

// File: rtl/radix4_operand_loader.sv
// Push-button operand loader and start/done handshake for the Radix-4 multiplier board demo.
// Optional RUN watchdog is built when OPLOAD_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module radix4_operand_loader #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             key_a_n,
  input  logic             key_b_n,
  input  logic             key_go_n,
  input  logic             mult_done,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             mult_start,
  output logic             a_valid,
  output logic             b_valid,
  output logic             busy,
  output logic             err
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  logic [2:0]       key_raw;
  logic [2:0]       press;
  logic             press_a;
  logic             press_b;
  logic             press_go;
  logic [WIDTH-1:0] sw_meta_reg;
  logic [WIDTH-1:0] sw_sync_reg;

  assign key_raw  = {key_go_n, key_b_n, key_a_n};
  assign press_a  = press[0];
  assign press_b  = press[1];
  assign press_go = press[2];

  // Per-key synchroniser, debouncer and falling-edge press detector.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_key
      logic             meta_reg;
      logic             sync_reg;
      logic             deb_reg;
      logic             deb_prev_reg;
      logic             press_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          meta_reg     <= 1'b1;
          sync_reg     <= 1'b1;
          deb_reg      <= 1'b1;
          deb_prev_reg <= 1'b1;
          press_reg    <= 1'b0;
          cnt_reg      <= '0;
        end else begin
          meta_reg     <= key_raw[gi];
          sync_reg     <= meta_reg;
          deb_prev_reg <= deb_reg;
          // Pulse lands one cycle after the debounced level falls.
          press_reg    <= deb_prev_reg & ~deb_reg;
          if (sync_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            deb_reg <= sync_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= sw;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  state_t           state_reg;
  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic             a_valid_reg;
  logic             b_valid_reg;
  logic             mult_start_reg;
  logic             busy_reg;

`ifdef OPLOAD_TIMEOUT_EN
  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             err_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= LOAD;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      a_valid_reg    <= 1'b0;
      b_valid_reg    <= 1'b0;
      mult_start_reg <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef OPLOAD_TIMEOUT_EN
      tmo_cnt_reg    <= '0;
      err_reg        <= 1'b0;
`endif
    end else begin
      mult_start_reg <= 1'b0;
      case (state_reg)
        LOAD: begin
          if (press_a) begin
            op_a_reg    <= sw_sync_reg;
            a_valid_reg <= 1'b1;
          end
          if (press_b) begin
            op_b_reg    <= sw_sync_reg;
            b_valid_reg <= 1'b1;
          end
          // Go sees the flags as they were before any load in this same cycle.
          if (press_go && a_valid_reg && b_valid_reg) begin
            state_reg      <= START;
            mult_start_reg <= 1'b1;
            busy_reg       <= 1'b1;
`ifdef OPLOAD_TIMEOUT_EN
            err_reg        <= 1'b0;
`endif
          end
        end

        START: begin
          state_reg <= RUN;
`ifdef OPLOAD_TIMEOUT_EN
          tmo_cnt_reg <= '0;
`endif
        end

        RUN: begin
          if (mult_done) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
          end
`ifdef OPLOAD_TIMEOUT_EN
          else if (tmo_cnt_reg == TMO_LAST) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            err_reg   <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
`endif
        end

        DONE: begin
          // Loading one operand invalidates the other so a fresh pair is required.
          if (press_a || press_b) begin
            if (press_a) begin
              op_a_reg    <= sw_sync_reg;
              a_valid_reg <= 1'b1;
            end else begin
              a_valid_reg <= 1'b0;
            end
            if (press_b) begin
              op_b_reg    <= sw_sync_reg;
              b_valid_reg <= 1'b1;
            end else begin
              b_valid_reg <= 1'b0;
            end
            state_reg <= LOAD;
          end else if (press_go) begin
            state_reg      <= START;
            mult_start_reg <= 1'b1;
            busy_reg       <= 1'b1;
`ifdef OPLOAD_TIMEOUT_EN
            err_reg        <= 1'b0;
`endif
          end
        end

        default: begin
          state_reg <= LOAD;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign op_a       = op_a_reg;
  assign op_b       = op_b_reg;
  assign a_valid    = a_valid_reg;
  assign b_valid    = b_valid_reg;
  assign mult_start = mult_start_reg;
  assign busy       = busy_reg;

`ifdef OPLOAD_TIMEOUT_EN
  assign err = err_reg;
`else
  assign err = 1'b0;
  // Without the watchdog the limit has no effect; the empty block keeps it referenced.
  if (TIMEOUT_CYCLES < 0) begin : g_tmo_unused
  end
`endif

endmodule

// File: tb/tb_radix4_operand_loader.sv
// Directed bench for radix4_operand_loader: table-driven key loads plus start/run/done,
// reset-in-run and watchdog sequences.
`timescale 1ns/1ps

module tb_radix4_operand_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw = 8'h00;
  logic       key_a_n = 1'b1;
  logic       key_b_n = 1'b1;
  logic       key_go_n = 1'b1;
  logic       mult_done = 1'b0;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       mult_start;
  logic       a_valid;
  logic       b_valid;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  radix4_operand_loader #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .key_a_n(key_a_n),
    .key_b_n(key_b_n),
    .key_go_n(key_go_n),
    .mult_done(mult_done),
    .op_a(op_a),
    .op_b(op_b),
    .mult_start(mult_start),
    .a_valid(a_valid),
    .b_valid(b_valid),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  // Counts cycles in which mult_start is high.
  always @(negedge clk) if (mult_start) start_cnt++;

  typedef struct {
    int         key;      // 0=A, 1=B, 2=GO, 3=A and B together
    int         cycles;
    logic [7:0] swv;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       eav;
    logic       ebv;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic press(input int k, input int n, input logic [7:0] v, input int settle);
    @(negedge clk);
    sw = v;
    if (k == 0 || k == 3) key_a_n = 1'b0;
    if (k == 1 || k == 3) key_b_n = 1'b0;
    if (k == 2) key_go_n = 1'b0;
    repeat (n) @(negedge clk);
    key_a_n  = 1'b1;
    key_b_n  = 1'b1;
    key_go_n = 1'b1;
    repeat (settle) @(negedge clk);
  endtask

  task automatic done_pulse(input string name);
    @(negedge clk);
    mult_done = 1'b1;
    @(posedge clk);
    #1;
    chk(name, busy, 1'b0);
    @(negedge clk);
    mult_done = 1'b0;
  endtask

  initial begin
    int s0;
    int s;
    int e;

    vt[0] = '{1, 3,  8'h04, 8'hFF, 8'h00, 1'b1, 1'b0};  // 3-cycle glitch ignored
    vt[1] = '{1, 10, 8'h04, 8'hFF, 8'h04, 1'b1, 1'b1};
    vt[2] = '{0, 2,  8'h55, 8'hFF, 8'h04, 1'b1, 1'b1};
    vt[3] = '{0, 3,  8'hAA, 8'hFF, 8'h04, 1'b1, 1'b1};
    vt[4] = '{0, 4,  8'h5A, 8'h5A, 8'h04, 1'b1, 1'b1};  // exactly DEBOUNCE_CYCLES
    vt[5] = '{3, 10, 8'h3C, 8'h3C, 8'h3C, 1'b1, 1'b1};
    vt[6] = '{1, 10, 8'h04, 8'h3C, 8'h04, 1'b1, 1'b1};
    vt[7] = '{0, 10, 8'hFF, 8'hFF, 8'h04, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_a", op_a, 8'h00);
    chk("rst_op_b", op_b, 8'h00);
    chk("rst_valids", {a_valid, b_valid}, 2'b00);
    chk("rst_start_busy_err", {mult_start, busy, err}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Exact load latency: 2 sync + 4 debounce + 1 press cycle after the first low sample.
    sw = 8'hFF;
    key_a_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 6) chk("lat_a_valid_early", a_valid, 1'b0);
      if (k == 7) begin
        chk("lat_a_valid", a_valid, 1'b1);
        chk("lat_op_a", op_a, 8'hFF);
      end
      if (k == 8) sw = 8'h11;
    end
    @(negedge clk);
    key_a_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("single_load_op_a", op_a, 8'hFF);
    $display("latency: op_a=%02h a_valid=%0b", op_a, a_valid);

    for (int i = 0; i < 8; i++) begin
      press(vt[i].key, vt[i].cycles, vt[i].swv, 12);
      $display("vec %0d key=%0d cyc=%0d sw=%02h -> op_a=%02h op_b=%02h av=%0b bv=%0b",
               i, vt[i].key, vt[i].cycles, vt[i].swv, op_a, op_b, a_valid, b_valid);
      chk($sformatf("vec%0d_op_a", i), op_a, vt[i].ea);
      chk($sformatf("vec%0d_op_b", i), op_b, vt[i].eb);
      chk($sformatf("vec%0d_a_valid", i), a_valid, vt[i].eav);
      chk($sformatf("vec%0d_b_valid", i), b_valid, vt[i].ebv);
      chk($sformatf("vec%0d_busy", i), busy, 1'b0);
    end

    // Start, keys ignored in RUN, done.
    s0 = start_cnt;
    press(2, 10, 8'h99, 10);
    chk("go_start_pulses", start_cnt - s0, 1);
    chk("go_busy", busy, 1'b1);
    chk("go_start_low", mult_start, 1'b0);
    press(0, 6, 8'h33, 10);
    press(1, 6, 8'h33, 10);
    chk("run_op_a_held", op_a, 8'hFF);
    chk("run_op_b_held", op_b, 8'h04);
    chk("run_busy", busy, 1'b1);
    done_pulse("done_busy");
    $display("run: starts=%0d op_a=%02h op_b=%02h busy=%0b", start_cnt - s0, op_a, op_b, busy);

    // DONE, load A: B invalidated.
    press(0, 10, 8'h77, 12);
    chk("done_load_op_a", op_a, 8'h77);
    chk("done_load_valids", {a_valid, b_valid}, 2'b10);
    chk("done_load_op_b_held", op_b, 8'h04);

    // Go with only A valid is ignored.
    s0 = start_cnt;
    press(2, 10, 8'h00, 12);
    chk("go_no_b_starts", start_cnt - s0, 0);
    chk("go_no_b_busy", busy, 1'b0);
    $display("go without B: starts=%0d busy=%0b", start_cnt - s0, busy);

    press(1, 10, 8'h0C, 12);
    chk("reload_b", {op_b, b_valid}, {8'h0C, 1'b1});

    // Run, done, then re-run same operands from DONE.
    press(2, 10, 8'h00, 10);
    done_pulse("done2_busy");
    s0 = start_cnt;
    press(2, 10, 8'h00, 10);
    chk("rerun_starts", start_cnt - s0, 1);
    chk("rerun_busy", busy, 1'b1);
    chk("rerun_ops", {op_a, op_b}, {8'h77, 8'h0C});
    $display("rerun: starts=%0d busy=%0b", start_cnt - s0, busy);

    // Reset while in RUN.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rrun_ops", {op_a, op_b}, 16'h0000);
    chk("rrun_flags", {a_valid, b_valid, mult_start, busy, err}, 5'b00000);
    @(negedge clk);
    rst = 1'b0;
    done_pulse("rrun_done_ignored");
    repeat (5) @(negedge clk);
    chk("rrun_busy_after", busy, 1'b0);
    s0 = start_cnt;
    press(2, 10, 8'h00, 12);
    chk("rrun_go_ignored", start_cnt - s0, 0);
    $display("reset in run: busy=%0b starts=%0d", busy, start_cnt - s0);

    // Watchdog: withhold mult_done.
    press(0, 10, 8'h12, 12);
    press(1, 10, 8'h34, 12);
    s = -1;
    e = -1;
    @(negedge clk);
    key_go_n = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (mult_start && s < 0) s = i;
      if (err && e < 0) e = i;
      if (i == 9) key_go_n = 1'b1;
    end
    chk("tmo_started", s >= 0, 1'b1);
`ifdef OPLOAD_TIMEOUT_EN
    chk("tmo_latency", e - s, 65);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_err", err, 1'b1);
    press(2, 10, 8'h00, 10);
    chk("tmo_err_cleared", err, 1'b0);
    chk("tmo_rerun_busy", busy, 1'b1);
    done_pulse("tmo_done_busy");
`else
    chk("no_tmo_err", e < 0, 1'b1);
    chk("no_tmo_busy", busy, 1'b1);
    done_pulse("no_tmo_done_busy");
    chk("no_tmo_err_after", err, 1'b0);
`endif
    $display("watchdog: start@%0d err@%0d busy=%0b err=%0b", s, e, busy, err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
